br_flow_arb_rr_hold: RTL
========================

Name: br_flow_arb_rr_hold

Overview:
- Round-robin arbiter that merges NumFlows ready-valid push flows onto one ready-valid pop flow.
- The grant is held while the pop side is backpressured. This keeps pop_valid and pop_data stable, so downstream valid and data stability checks pass.
- It sits in front of shared flow resources such as FIFO write ports and crossbar outputs.
- The datapath is combinational. Priority and lock are registered.

Parameters:
- NumFlows, 2, number of push flows; must be at least 2.
- Width, 1, data width per flow; must be at least 1.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-high.
- push_valid  input  NumFlows  per-flow valid.
- push_ready  output  NumFlows  per-flow ready.
- push_data  input  NumFlows x Width  per-flow data.
- pop_valid  output  1  merged valid.
- pop_ready  input  1  downstream ready.
- pop_data  output  Width  data of the granted flow.
- pop_grant  output  NumFlows  onehot index of the granted flow; all zeros when pop_valid=0.

Behaviour:
- Only one clock (clk). Reset (rst) is asynchronous and active-high.
- State:
  - last_q: index of the flow that was last accepted, $clog2(NumFlows) bits. Reset value NumFlows-1, so flow 0 has highest priority after reset.
  - lock_q: 1 bit, reset 0.
  - lock_idx_q: $clog2(NumFlows) bits, reset 0.
- Outputs during reset: pop_valid=0, push_ready=0 and pop_grant=0 while rst=1, regardless of inputs.
- Priority order when unlocked: last_q+1, last_q+2, … modulo NumFlows. Wrap-around uses compare-and-subtract, not a power-of-2 mask.
- Grant selection:
  - When lock_q=1, the grant is lock_idx_q unconditionally; other requesters are ignored.
  - When lock_q=0, the grant is the highest-priority flow with push_valid=1. The grant is none if no flow is valid.
- Output equations:
  - pop_valid = (some flow is granted).
  - pop_data = push_data[grant].
  - push_ready[i] = pop_ready && pop_grant[i] && !rst.
  - Ungranted flows see ready=0.
- Latency: zero cycles from push to pop; no storage.
- Transfer: pop_valid && pop_ready in a cycle. On a transfer, last_q <= grant index and lock_q <= 0.
- Backpressure: pop_valid && !pop_ready with lock_q=0. Then lock_q <= 1 and lock_idx_q <= grant index; last_q is unchanged.
- Lock release: only by a transfer on the locked flow. While locked, the locked flow's push_valid must stay 1; this is the upstream protocol obligation.
- Locked flow drops valid (protocol violation):
  - pop_valid falls to 0 and lock_q clears on the next edge.
  - No transfer occurs.
- Idle (no push_valid): last_q and lock_q hold; pop_grant=0.
- Single requester: it is granted every cycle it is valid, at full throughput of one transfer per cycle.
- Reset mid-lock: the asynchronous reset clears lock_q and restores last_q=NumFlows-1 immediately. No transfer occurs in the reset cycle.
- Fairness: each continuously valid flow is accepted within NumFlows transfers.

Optional Feature:
- Macro: BR_FLOW_ARB_RR_HOLD_CHECKS_EN.
- Defined:
  - Per push flow, assert push_valid[i] && !push_ready[i] |=> push_valid[i] && $stable(push_data[i]).
  - On pop, assert pop_valid && !pop_ready |=> pop_valid && $stable(pop_data) && $stable(pop_grant).
  - Assert $onehot0(pop_grant).
  - Cover a lock held for at least 3 cycles.
  - Cover every flow granted at least once.
  - All checks are disabled while rst=1.
- Undefined: no assertions or covers are compiled in. The RTL datapath and ports are identical in both cases.

Test Plan:
1. Reset, NumFlows=3, Width=8, push_valid=3'b111, pop_ready=1 → grants 0,1,2,0,… on consecutive cycles; pop_data matches each flow's data; 4 transfers in 4 cycles.
2. After reset, only flow 2 is valid with data 0xA5 and pop_ready=0 for 3 cycles; flow 0 raises valid in cycle 2 → pop_grant=3'b100 and pop_data=0xA5 on all 3 cycles. In cycle 4, pop_ready=1 → flow 2 transfers. In cycle 5, flow 0 is granted.
3. last_q=1, flows 0 and 2 valid, pop_ready=1 → flow 2 is granted first (wrap-around priority), then flow 0.
4. Locked on flow 1, rst pulsed mid-lock → pop_valid=0 during reset. After release with flows 0 and 1 valid, flow 0 is granted.
5. With BR_FLOW_ARB_RR_HOLD_CHECKS_EN defined, flow 1 changes data while backpressured → push stability assertion fires. Without the macro, the same stimulus runs with no assertion.
6. NumFlows=5 (non-power-of-2), all valid, random pop_ready → each flow is accepted within 5 transfers of becoming valid; pop_grant is always onehot0.

Source files
------------

// File: rtl/br_flow_arb_rr_hold.sv
// br_flow_arb_rr_hold: round-robin arbiter that merges NumFlows ready-valid
// push flows onto one ready-valid pop flow. When the pop side backpressures,
// the grant is locked to the presented flow so that pop_valid, pop_data and
// pop_grant stay stable until that flow transfers. The datapath is
// combinational. Only the priority pointer and the lock are registered.
//
// Optional macro BR_FLOW_ARB_RR_HOLD_CHECKS_EN compiles in protocol
// assertions and covers. Ports and datapath do not change with the macro.
//
// Ports:
//   clk         clock
//   rst         asynchronous active-high reset
//   push_valid  [NumFlows]         per-flow valid
//   push_ready  [NumFlows]         per-flow ready (granted flow only)
//   push_data   [NumFlows][Width]  per-flow data
//   pop_valid   merged valid
//   pop_ready   downstream ready
//   pop_data    [Width]            data of the granted flow
//   pop_grant   [NumFlows]         onehot grant, zero when pop_valid=0
module br_flow_arb_rr_hold #(
  parameter int unsigned NumFlows = 2,
  parameter int unsigned Width    = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NumFlows-1:0]             push_valid,
  output logic [NumFlows-1:0]             push_ready,
  input  logic [NumFlows-1:0][Width-1:0]  push_data,
  output logic                            pop_valid,
  input  logic                            pop_ready,
  output logic [Width-1:0]                pop_data,
  output logic [NumFlows-1:0]             pop_grant
);

  localparam int unsigned IdxW = (NumFlows > 1) ? $clog2(NumFlows) : 1;
  localparam int unsigned CntW = IdxW + 1;
  localparam logic [IdxW-1:0] LastRst = IdxW'(NumFlows - 1);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_e;

  lock_e           lock_q, lock_d;
  logic [IdxW-1:0] lock_idx_q, lock_idx_d;
  logic [IdxW-1:0] last_q, last_d;

  logic [IdxW-1:0] gnt_idx;
  logic            gnt_any;
  logic [CntW-1:0] cand;

  // State register: priority pointer and lock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q     <= UNLOCKED;
      lock_idx_q <= '0;
      last_q     <= LastRst;
    end else begin
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      last_q     <= last_d;
    end
  end

  // Grant selection. Scanning from lowest to highest priority lets the
  // highest-priority valid flow win. Wrap uses compare-and-subtract so
  // non-power-of-2 NumFlows rotates correctly.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    if (lock_q == LOCKED) begin
      gnt_idx = lock_idx_q;
      gnt_any = push_valid[lock_idx_q];
    end else begin
      for (int k = int'(NumFlows); k > 0; k--) begin
        cand = CntW'(last_q) + CntW'(k);
        if (cand >= CntW'(NumFlows)) begin
          cand = cand - CntW'(NumFlows);
        end
        if (push_valid[cand[IdxW-1:0]]) begin
          gnt_any = 1'b1;
          gnt_idx = cand[IdxW-1:0];
        end
      end
    end
  end

  // Combinational pop/push handshake, forced idle while in reset.
  always_comb begin
    pop_grant = '0;
    pop_valid = gnt_any && !rst;
    pop_data  = push_data[gnt_idx];
    if (pop_valid) begin
      pop_grant[gnt_idx] = 1'b1;
    end
    push_ready = pop_ready ? pop_grant : '0;
  end

  // Next state: a transfer advances the pointer and unlocks; a stalled
  // grant locks; a locked flow that drops valid releases the lock.
  always_comb begin
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    last_d     = last_q;
    if (gnt_any && pop_ready) begin
      last_d = gnt_idx;
      lock_d = UNLOCKED;
    end else if (gnt_any && (lock_q == UNLOCKED)) begin
      lock_d     = LOCKED;
      lock_idx_d = gnt_idx;
    end else if (!gnt_any) begin
      lock_d = UNLOCKED;
    end
  end

`ifdef BR_FLOW_ARB_RR_HOLD_CHECKS_EN
  for (genvar i = 0; i < int'(NumFlows); i++) begin : g_push_chk
    a_push_stable: assert property (@(posedge clk) disable iff (rst)
      push_valid[i] && !push_ready[i] |=> push_valid[i] && $stable(push_data[i]));
    c_flow_granted: cover property (@(posedge clk) disable iff (rst) pop_grant[i]);
  end

  a_pop_stable: assert property (@(posedge clk) disable iff (rst)
    pop_valid && !pop_ready |=> pop_valid && $stable(pop_data) && $stable(pop_grant));

  a_grant_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(pop_grant));

  c_lock_3: cover property (@(posedge clk) disable iff (rst) (lock_q == LOCKED) [*3]);
`endif

endmodule
